// File: rtl/sram_controller.sv
// 32-bit data-memory controller over a 16-bit external SRAM: each word is split
// into a low then a high halfword access, each held for WAIT_CYCLES cycles.
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_r_en,
  input  logic        MEM_w_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_DQ_oe,
  output logic        SRAM_WE_N
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_saved_addr, r_saved_data;
  logic          w_req, w_phase, w_last, w_abort;
  logic [31:0]   w_off;
  logic [16:0]   w_word;
  logic          w_unused;

  assign w_req   = MEM_r_en | MEM_w_en;
  assign w_phase = r_state inside {WR_LO, WR_HI, RD_LO, RD_HI};
  assign w_last  = (r_cnt == LAST);
  assign w_abort = w_phase && !w_req;

  // Wrap-around subtraction: addresses below the base alias to the top of SRAM.
  assign w_off    = r_saved_addr - ADDR_BASE;
  assign w_word   = w_off[18:2];
  assign w_unused = ^{w_off[31:19], w_off[1:0]};

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (MEM_w_en)      w_next = WR_LO;
        else if (MEM_r_en) w_next = RD_LO;
      end
      WR_LO: if (w_abort) w_next = IDLE; else if (w_last) w_next = WR_HI;
      WR_HI: if (w_abort) w_next = IDLE; else if (w_last) w_next = DONE;
      RD_LO: if (w_abort) w_next = IDLE; else if (w_last) w_next = RD_HI;
      RD_HI: if (w_abort) w_next = IDLE; else if (w_last) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_DQ_oe  = 1'b0;
    SRAM_WE_N   = 1'b1;
    ready       = 1'b0;
    case (r_state)
      IDLE:  ready = ~w_req;
      DONE:  ready = 1'b1;
      WR_LO: begin
        SRAM_ADDR   = {w_word, 1'b0};
        SRAM_DQ_out = r_saved_data[15:0];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      WR_HI: begin
        SRAM_ADDR   = {w_word, 1'b1};
        SRAM_DQ_out = r_saved_data[31:16];
        SRAM_DQ_oe  = 1'b1;
        SRAM_WE_N   = 1'b0;
      end
      RD_LO: SRAM_ADDR = {w_word, 1'b0};
      RD_HI: SRAM_ADDR = {w_word, 1'b1};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_saved_addr <= '0;
      r_saved_data <= '0;
      read_data    <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_phase && (w_next == r_state)) ? r_cnt + 1'b1 : '0;
      if (r_state == IDLE && w_req) begin
        r_saved_addr <= address;
        if (MEM_w_en) r_saved_data <= write_data;
      end
      // A withdrawn request on the final wait cycle does not capture its half.
      if (w_last && !w_abort) begin
        if (r_state == RD_LO) read_data[15:0]  <= SRAM_DQ_in;
        if (r_state == RD_HI) read_data[31:16] <= SRAM_DQ_in;
      end
    end
  end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Multi-cycle controller for the 32-bit data memory behind the MEM stage. It drives an external 16-bit-wide SRAM.
- Accepts the MEM stage's read/write request, splits each 32-bit word into two 16-bit SRAM accesses, and inserts wait states.
- Holds `ready` low while an access is in flight. The top level uses `~ready` as the pipeline freeze for IF/ID/EXE/MEM stage registers.

Parameters:
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.
- WAIT_CYCLES, 3: cycles each 16-bit half-access occupies (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- MEM_r_en  input  1  read request from MEM stage.
- MEM_w_en  input  1  write request from MEM stage.
- address  input  32  byte address (ALU result).
- write_data  input  32  store data (val_rm).
- read_data  output  32  loaded word, registered.
- ready  output  1  high = no access pending or access complete this cycle.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_DQ_out  output  16  data driven to SRAM.
- SRAM_DQ_in  input  16  data returned from SRAM.
- SRAM_DQ_oe  output  1  1 = controller drives the data bus.
- SRAM_WE_N  output  1  SRAM write strobe, active-low.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, counter=0.
  - saved_addr=0, saved_data=0, read_data=0.
  - SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1.
  - ready = ~(MEM_r_en|MEM_w_en).
- Address map:
  - word = (address - ADDR_BASE) >> 2, computed modulo 2^32 and truncated to 17 bits. No range check; addresses below the base wrap.
  - Low half at SRAM_ADDR={word,1'b0}; high half at {word,1'b1}.
  - address[1:0] is ignored.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, DONE.
- IDLE:
  - If MEM_w_en: latch address/write_data, go to WR_LO.
  - Else if MEM_r_en: latch address, go to RD_LO.
  - Write has priority when both are high.
- Each LO/HI phase lasts exactly WAIT_CYCLES cycles.
  - counter counts 0..WAIT_CYCLES-1 and clears on phase change.
  - LO->HI and HI->DONE occur on counter==WAIT_CYCLES-1.
- Write phases:
  - SRAM_DQ_oe=1, SRAM_WE_N=0.
  - SRAM_DQ_out = saved_data[15:0] in LO, saved_data[31:16] in HI.
- Read phases:
  - SRAM_DQ_oe=0, SRAM_WE_N=1.
  - On the last cycle of RD_LO, capture SRAM_DQ_in into read_data[15:0].
  - On the last cycle of RD_HI, capture SRAM_DQ_in into read_data[31:16].
  - read_data holds its value otherwise, and is unchanged by writes.
- Outside LO/HI phases: SRAM_ADDR=0, SRAM_DQ_oe=0, SRAM_WE_N=1.
- DONE: lasts 1 cycle, then IDLE unconditionally. The pipeline advances on this edge.
- ready (combinational):
  - ready = 1 if state==DONE.
  - ready = ~(MEM_r_en|MEM_w_en) if state==IDLE.
  - ready = 0 otherwise.
- Latency: a request first seen in IDLE at cycle 0 gives ready=0 for cycles 0..2*WAIT_CYCLES, and ready=1 at cycle 2*WAIT_CYCLES+1 (cycle 7 for the default).
- Back-to-back requests: the next request is sampled in the IDLE cycle after DONE. There are no dropped or duplicated accesses.
- Request withdrawn mid-access (both enables low, e.g. flush):
  - The next edge returns to IDLE, releases the bus, and sets WE_N=1.
  - read_data keeps any half already captured.
- Request inputs may change while busy; the latched copies are used.
- Reset mid-access: immediate return to the reset values. A partial SRAM write (low half only) is acceptable.

Test Plan:
- Reset with MEM_w_en=1 held -> all outputs at reset values, ready=0. After rst release, write starts at the next edge.
- Write 0xDEADBEEF to address 1028, W=3 -> cycles 1-3: SRAM_ADDR=2, DQ_out=0xBEEF, WE_N=0. Cycles 4-6: SRAM_ADDR=3, DQ_out=0xDEAD. Cycle 7: ready=1. Cycle 8: IDLE.
- Read 1028 from an SRAM model holding the above -> read_data=0xDEADBEEF at cycle 7, ready=1 at cycle 7, WE_N=1 and DQ_oe=0 throughout.
- MEM_r_en and MEM_w_en both high, address 1024, data 0x12345678 -> write performed (halves at addr 0,1), read_data unchanged.
- Two back-to-back reads to 1024 then 1032, with enables held continuously -> exactly two 7-cycle access sequences separated by one IDLE cycle. read_data updates to the 1024 word first, then the 1032 word.
- Read started, enables dropped during RD_HI cycle 1 -> IDLE next cycle, ready=1, bus released. read_data[15:0] updated, [31:16] not updated.
